tx_arbiter: RTL

TX_ARBITER -- requirements
Module: tx_arbiter

---
 rtl/router_pkg.sv | 17 +
 rtl/rr_picker.sv | 32 +++
 rtl/tx_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the transmit arbiter: packet width, FSM encoding, watchdog default.
package router_pkg;

  localparam int DATA_W          = 55;
  localparam int DEF_TIMEOUT_CYC = 1024;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } arb_state_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first requesting port at or after ptr, wrapping at N.
module rr_picker #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic             found,
  output logic [PTR_W-1:0] idx
);

  logic [PTR_W-1:0] cand [N];
  logic [N-1:0]     hit;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      assign cand[gi] = PTR_W'((int'(ptr) + gi) % N);
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  // Scan from the farthest offset down so the nearest hit wins.
  always_comb begin
    found = |hit;
    idx   = cand[0];
    for (int k = N - 1; k >= 0; k--) begin
      if (hit[k]) idx = cand[k];
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter handing packets from NUM_REQ ports to one serial transmitter.
// Optional watchdog on a stuck transmitter enabled by defining TXARB_TIMEOUT_EN.
module tx_arbiter
  import router_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = router_pkg::DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                        Clk_S,
  input  logic                        Rst_n,
  input  logic [NUM_REQ*DATA_W-1:0]   Req_Data,
  input  logic [NUM_REQ-1:0]          Req_Valid,
  output logic [NUM_REQ-1:0]          Req_Ack,
  output logic [DATA_W-1:0]           TX_Data,
  output logic                        TX_Data_Valid,
  input  logic                        TX_Ready,
  output logic [$clog2(NUM_REQ)-1:0]  Grant_Id,
  output logic                        TX_Busy
`ifdef TXARB_TIMEOUT_EN
  ,output logic                       Timeout_Err
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  arb_state_t          state_reg, state_next;
  logic [ID_W-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [ID_W-1:0]     grant_reg, grant_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic                valid_reg, valid_next;
  logic [NUM_REQ-1:0]  ack_reg, ack_next;
  logic                pick_found;
  logic [ID_W-1:0]     pick_idx;
  logic                timeout_hit;

  rr_picker #(
    .N     (NUM_REQ),
    .PTR_W (ID_W)
  ) u_picker (
    .req   (Req_Valid),
    .ptr   (rr_ptr_reg),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef TXARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             err_reg;

  // Counter spans both busy states, so the limit covers a stalled launch or a stalled finish.
  assign timeout_hit = (state_reg != ST_IDLE) && (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      if (state_reg == ST_IDLE) cnt_reg <= '0;
      else                      cnt_reg <= cnt_reg + CNT_W'(1);
      if (timeout_hit)          err_reg <= 1'b1;
    end
  end

  assign Timeout_Err = err_reg;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    grant_next  = grant_reg;
    data_next   = data_reg;
    valid_next  = valid_reg;
    ack_next    = '0;
    case (state_reg)
      ST_IDLE: begin
        if (pick_found && TX_Ready) begin
          data_next          = Req_Data[int'(pick_idx)*DATA_W +: DATA_W];
          grant_next         = pick_idx;
          ack_next[pick_idx] = 1'b1;
          state_next         = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!TX_Ready) begin
          valid_next = 1'b0;
          state_next = ST_WAIT_DONE;
        end else begin
          valid_next = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (TX_Ready) begin
          state_next  = ST_IDLE;
          rr_ptr_next = ID_W'(wrap_inc(int'(grant_reg), NUM_REQ));
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (timeout_hit) begin
      state_next  = ST_IDLE;
      valid_next  = 1'b0;
      rr_ptr_next = ID_W'(wrap_inc(int'(grant_reg), NUM_REQ));
    end
  end

  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg  <= ST_IDLE;
      rr_ptr_reg <= '0;
      grant_reg  <= '0;
      data_reg   <= '0;
      valid_reg  <= 1'b0;
      ack_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      grant_reg  <= grant_next;
      data_reg   <= data_next;
      valid_reg  <= valid_next;
      ack_reg    <= ack_next;
    end
  end

  assign Req_Ack       = ack_reg;
  assign TX_Data       = data_reg;
  assign TX_Data_Valid = valid_reg;
  assign Grant_Id      = grant_reg;
  assign TX_Busy       = (state_reg != ST_IDLE);

endmodule
